// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared hour types, constants and display helpers
package time_pkg;

  typedef logic [4:0] hour_t;

  localparam hour_t HOUR_MAX = 5'd23;

  typedef enum logic [1:0] {IDLE, ON, OFF} chime_state_t;

  typedef struct packed {
    logic [1:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // 0 reads as 12 on a 12h face; 13..23 fold down by twelve.
  function automatic logic [3:0] hour_to_12h(input hour_t h);
    if (h == 5'd0)
      return 4'd12;
    else if (h > 5'd12)
      return 4'(h - 5'd12);
    else
      return 4'(h);
  endfunction

  function automatic bcd2_t to_bcd2(input hour_t v);
    bcd2_t r;
    if (v >= 5'd20) begin
      r.tens = 2'd2;
      r.ones = 4'(v - 5'd20);
    end else if (v >= 5'd10) begin
      r.tens = 2'd1;
      r.ones = 4'(v - 5'd10);
    end else begin
      r.tens = 2'd0;
      r.ones = 4'(v);
    end
    return r;
  endfunction

endpackage

// File: rtl/time_hour_chime.sv
// rtl/time_hour_chime.sv - hourly chime burst FSM with beep and cycle counters
module time_hour_chime
  import time_pkg::*;
#(
  parameter int CHIME_ON  = 4,
  parameter int CHIME_OFF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger_i,
  input  logic [3:0] beeps_i,
  input  logic       chime_en_i,
  input  logic       abort_i,
  output logic       chime_out_o,
  output logic       chime_busy_o
);

  localparam int CMAX = (CHIME_ON > CHIME_OFF) ? CHIME_ON : CHIME_OFF;
  localparam int CW   = $clog2(CMAX + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t ON_LAST  = cnt_t'(CHIME_ON - 1);
  localparam cnt_t OFF_LAST = cnt_t'(CHIME_OFF - 1);

  chime_state_t state_q;
  cnt_t         cnt_q;
  logic [3:0]   beeps_q;
  logic         chime_out_q;
  logic         busy_q;

  // A fresh trigger always restarts the burst, whatever state we are in.
  always_ff @(posedge clk) begin
    if (rst || !chime_en_i || abort_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      beeps_q     <= '0;
      chime_out_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (trigger_i) begin
      state_q     <= ON;
      cnt_q       <= '0;
      beeps_q     <= beeps_i;
      chime_out_q <= 1'b1;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        ON: begin
          if (cnt_q == ON_LAST) begin
            state_q     <= OFF;
            cnt_q       <= '0;
            chime_out_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        OFF: begin
          if (cnt_q == OFF_LAST) begin
            cnt_q   <= '0;
            beeps_q <= beeps_q - 4'd1;
            if (beeps_q > 4'd1) begin
              state_q     <= ON;
              chime_out_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign chime_out_o  = chime_out_q;
  assign chime_busy_o = busy_q;

endmodule

// File: rtl/time_hour_counter.sv
// rtl/time_hour_counter.sv - hour register with set/carry priority, 12h/24h BCD display and chime
module time_hour_counter
  import time_pkg::*;
#(
  parameter int CHIME_ON  = 4,
  parameter int CHIME_OFF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cin_hour,
  input  logic       set_time_en,
  input  logic [4:0] set_time_hour,
  input  logic       mode_12h,
  input  logic       chime_en,
  output logic [4:0] out_hour,
  output logic [1:0] disp_tens,
  output logic [3:0] disp_ones,
  output logic       disp_pm,
  output logic       cout_day,
  output logic       set_err,
  output logic       chime_out,
  output logic       chime_busy
);

  hour_t      hour_q, hour_d;
  logic       cout_q, cout_d;
  logic       err_q, err_d;
  logic       trig_q, trig_d;
  logic [3:0] beeps_q, beeps_d;
  hour_t      disp_val;
  bcd2_t      bcd;

  // Set wins over carry; a carry in the same cycle as a set is discarded.
  always_comb begin
    hour_d  = hour_q;
    err_d   = err_q;
    cout_d  = 1'b0;
    trig_d  = 1'b0;
    beeps_d = beeps_q;
    if (set_time_en) begin
      if (set_time_hour <= HOUR_MAX) begin
        hour_d = set_time_hour;
        err_d  = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (cin_hour) begin
      if (hour_q == HOUR_MAX) begin
        hour_d = '0;
        cout_d = 1'b1;
      end else begin
        hour_d = hour_q + 5'd1;
      end
      trig_d  = chime_en;
      beeps_d = hour_to_12h(hour_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hour_q  <= '0;
      err_q   <= 1'b0;
      cout_q  <= 1'b0;
      trig_q  <= 1'b0;
      beeps_q <= '0;
    end else begin
      hour_q  <= hour_d;
      err_q   <= err_d;
      cout_q  <= cout_d;
      trig_q  <= trig_d;
      beeps_q <= beeps_d;
    end
  end

  always_comb begin
    disp_val = mode_12h ? {1'b0, hour_to_12h(hour_q)} : hour_q;
    bcd      = to_bcd2(disp_val);
  end

  time_hour_chime #(
    .CHIME_ON (CHIME_ON),
    .CHIME_OFF(CHIME_OFF)
  ) u_chime (
    .clk         (clk),
    .rst         (rst),
    .trigger_i   (trig_q),
    .beeps_i     (beeps_q),
    .chime_en_i  (chime_en),
    .abort_i     (set_time_en | cin_hour),
    .chime_out_o (chime_out),
    .chime_busy_o(chime_busy)
  );

  assign out_hour  = hour_q;
  assign disp_tens = bcd.tens;
  assign disp_ones = bcd.ones;
  assign disp_pm   = (hour_q >= 5'd12);
  assign cout_day  = cout_q;
  assign set_err   = err_q;

endmodule

// File: tb/tb_time_hour_counter.sv
// tb/tb_time_hour_counter.sv - self-checking bench for time_hour_counter
module tb_time_hour_counter;

  logic       clk = 1'b0;
  logic       rst, cin_hour, set_time_en, mode_12h, chime_en;
  logic [4:0] set_time_hour;
  logic [4:0] out_hour;
  logic [1:0] disp_tens;
  logic [3:0] disp_ones;
  logic       disp_pm, cout_day, set_err, chime_out, chime_busy;

  always #5 clk = ~clk;

  time_hour_counter #(.CHIME_ON(4), .CHIME_OFF(4)) dut (
    .clk(clk), .rst(rst), .cin_hour(cin_hour), .set_time_en(set_time_en),
    .set_time_hour(set_time_hour), .mode_12h(mode_12h), .chime_en(chime_en),
    .out_hour(out_hour), .disp_tens(disp_tens), .disp_ones(disp_ones),
    .disp_pm(disp_pm), .cout_day(cout_day), .set_err(set_err),
    .chime_out(chime_out), .chime_busy(chime_busy)
  );

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic       set_en;
    logic [4:0] set_hour;
    logic       cin;
    logic       mode;
    logic       cen;
    logic [4:0] e_hour;
    logic [1:0] e_tens;
    logic [3:0] e_ones;
    logic       e_pm, e_cout, e_err, e_busy;
  } vec_t;

  typedef struct {
    logic [4:0] hour;
    logic [1:0] tens;
    logic [3:0] ones;
    logic       pm, cout, err, busy;
  } exp_t;

  typedef struct {
    logic out;
    logic busy;
  } chime_exp_t;

  vec_t       vt[19];
  exp_t       sb[$];
  chime_exp_t csb[$];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t       e;
    chime_exp_t ce;
    int         model_hour;
    int         couts;

    rst = 1'b1; cin_hour = 1'b0; set_time_en = 1'b0; set_time_hour = '0;
    mode_12h = 1'b0; chime_en = 1'b0;
    step();
    rst = 1'b0;
    check("reset out_hour", out_hour, 0);
    check("reset cout_day", cout_day, 0);
    check("reset set_err", set_err, 0);
    check("reset chime_out", chime_out, 0);
    check("reset chime_busy", chime_busy, 0);

    // full day of carries, 3 cycles apart
    model_hour = 0;
    couts = 0;
    for (int p = 0; p < 24; p++) begin
      cin_hour = 1'b1;
      step();
      cin_hour = 1'b0;
      model_hour = (model_hour == 23) ? 0 : model_hour + 1;
      check("carry out_hour", out_hour, model_hour);
      check("carry cout_day", cout_day, (model_hour == 0) ? 1 : 0);
      if (cout_day) couts++;
      step();
      if (cout_day) couts++;
      step();
      if (cout_day) couts++;
    end
    check("cout_day pulse count", couts, 1);

    vt[0]  = '{1'b1, 5'd17, 1'b0, 1'b0, 1'b0, 5'd17, 2'd1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 5'd25, 1'b0, 1'b0, 1'b0, 5'd17, 2'd1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 5'd5,  2'd0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 5'd24, 1'b0, 1'b0, 1'b0, 5'd5,  2'd0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 5'd3,  2'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 5'd9,  1'b1, 1'b0, 1'b1, 5'd9,  2'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 5'd9,  2'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 5'd0,  1'b0, 1'b1, 1'b0, 5'd0,  2'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 5'd12, 1'b0, 1'b1, 1'b0, 5'd12, 2'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 5'd13, 1'b0, 1'b1, 1'b0, 5'd13, 2'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b1, 5'd23, 1'b0, 1'b1, 1'b0, 5'd23, 2'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b1, 5'd23, 1'b0, 1'b0, 1'b0, 5'd23, 2'd2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b1, 5'd13, 1'b0, 1'b0, 1'b0, 5'd13, 2'd1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 5'd12, 2'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[14] = '{1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[15] = '{1'b1, 5'd22, 1'b0, 1'b0, 1'b0, 5'd22, 2'd2, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[16] = '{1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd23, 2'd2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[17] = '{1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  2'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[18] = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 19; i++) begin
      set_time_en   = vt[i].set_en;
      set_time_hour = vt[i].set_hour;
      cin_hour      = vt[i].cin;
      mode_12h      = vt[i].mode;
      chime_en      = vt[i].cen;
      sb.push_back('{vt[i].e_hour, vt[i].e_tens, vt[i].e_ones,
                     vt[i].e_pm, vt[i].e_cout, vt[i].e_err, vt[i].e_busy});
      step();
      e = sb.pop_front();
      check($sformatf("vec%0d out_hour", i), out_hour, e.hour);
      check($sformatf("vec%0d disp_tens", i), disp_tens, e.tens);
      check($sformatf("vec%0d disp_ones", i), disp_ones, e.ones);
      check($sformatf("vec%0d disp_pm", i), disp_pm, e.pm);
      check($sformatf("vec%0d cout_day", i), cout_day, e.cout);
      check($sformatf("vec%0d set_err", i), set_err, e.err);
      check($sformatf("vec%0d chime_busy", i), chime_busy, e.busy);
    end
    set_time_en = 1'b0; cin_hour = 1'b0; mode_12h = 1'b0;

    // 14 -> 15 carry: three beeps of 4 high / 4 low
    set_time_en = 1'b1; set_time_hour = 5'd14;
    step();
    set_time_en = 1'b0; chime_en = 1'b1; cin_hour = 1'b1;
    step();
    cin_hour = 1'b0;
    check("burst out_hour", out_hour, 15);
    check("trigger cycle chime_out", chime_out, 0);
    check("trigger cycle chime_busy", chime_busy, 0);
    for (int k = 0; k < 24; k++) csb.push_back('{((k % 8) < 4), 1'b1});
    csb.push_back('{1'b0, 1'b0});
    for (int k = 0; k < 25; k++) begin
      step();
      ce = csb.pop_front();
      check($sformatf("burst k%0d chime_out", k), chime_out, ce.out);
      check($sformatf("burst k%0d chime_busy", k), chime_busy, ce.busy);
    end

    // drop chime_en during the third beep
    set_time_en = 1'b1; set_time_hour = 5'd14;
    step();
    set_time_en = 1'b0; cin_hour = 1'b1;
    step();
    cin_hour = 1'b0;
    for (int k = 0; k < 17; k++) step();
    check("third beep chime_out", chime_out, 1);
    chime_en = 1'b0;
    step();
    check("chime_en drop chime_out", chime_out, 0);
    check("chime_en drop chime_busy", chime_busy, 0);
    chime_en = 1'b1;
    step();
    check("chime_en restore idle", chime_busy, 0);

    // reset mid-burst with set_err raised
    set_time_en = 1'b1; set_time_hour = 5'd14;
    step();
    set_time_hour = 5'd30;
    step();
    set_time_en = 1'b0;
    check("bad set err", set_err, 1);
    check("bad set hold", out_hour, 14);
    cin_hour = 1'b1;
    step();
    cin_hour = 1'b0;
    step(); step(); step();
    check("mid-burst busy", chime_busy, 1);
    rst = 1'b1;
    step();
    check("rst out_hour", out_hour, 0);
    check("rst cout_day", cout_day, 0);
    check("rst set_err", set_err, 0);
    check("rst chime_out", chime_out, 0);
    check("rst chime_busy", chime_busy, 0);
    rst = 1'b0;
    step();
    check("post rst busy", chime_busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
